// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_CALC = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    CALC = ST_CALC,
    DONE = ST_DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial
// subtract the divisor, keep the difference and set the quotient bit if non-negative.
module div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted_rem;
  logic [WIDTH:0] trial;

  // The extra top bit of the trial difference is the borrow/sign.
  always_comb begin
    shifted_rem = {rem_in, quo_in[WIDTH-1]};
    trial       = shifted_rem - {1'b0, divisor};
    if (trial[WIDTH]) begin
      rem_out = shifted_rem[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out = trial[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per CALC cycle.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands; unsigned otherwise.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int WIDTH_C = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t state, state_next;

  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   rem_w;
  logic [WIDTH-1:0]   quo_w;
  logic [WIDTH_C-1:0] cnt;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   dividend_mag;
  logic [WIDTH-1:0]   divisor_mag;
  logic [WIDTH-1:0]   final_quo;
  logic [WIDTH-1:0]   final_rem;
  logic [WIDTH-1:0]   zero_rem;
  logic               accept;
  logic               last_step;
  logic               zero_div;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_step = (state == CALC) && (cnt == WIDTH_C'(WIDTH - 1));
  assign zero_div  = (state == LOAD) && (divisor_q == '0);
  assign busy      = (state == LOAD) || (state == CALC);
  assign done      = (state == DONE);

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic quo_neg_q;
  logic rem_neg_q;

  // Work on magnitudes; the signs are re-applied when the result is registered.
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign final_quo    = quo_neg_q ? -step_quo : step_quo;
  assign final_rem    = rem_neg_q ? -step_rem : step_rem;
  assign zero_rem     = rem_neg_q ? -quo_w    : quo_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (accept) begin
      quo_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rem_neg_q <= dividend[WIDTH-1];
    end
  end
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
  assign final_quo    = step_quo;
  assign final_rem    = step_rem;
  assign zero_rem     = quo_w;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_w),
    .quo_in  (quo_w),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = (divisor_q == '0) ? DONE : CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    state_next = start ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Working registers run in CALC; result registers load only on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      divisor_q   <= '0;
      rem_w       <= '0;
      quo_w       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        divisor_q <= divisor_mag;
        quo_w     <= dividend_mag;
        rem_w     <= '0;
        cnt       <= '0;
      end else if (state == CALC) begin
        rem_w <= step_rem;
        quo_w <= step_quo;
        cnt   <= cnt + WIDTH_C'(1);
      end
      if (last_step) begin
        quotient    <= final_quo;
        remainder   <= final_rem;
        div_by_zero <= 1'b0;
      end else if (zero_div) begin
        quotient    <= '1;
        remainder   <= zero_rem;
        div_by_zero <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WIDTH=16.
// Latency is counted with the LOAD cycle after the accept edge as cycle 1.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (the LOAD cycle) of the accepted operation.
  task automatic start_op(input logic [W-1:0] dd, input logic [W-1:0] dv);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 1;
    while (!done && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: busy=%b done=%b dbz=%b expected 0 0 0", busy, done, div_by_zero);
    end
    n_checks++;
    if (quotient !== 16'h0000 || remainder !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL reset_results: q=%h r=%h expected 0000 0000", quotient, remainder);
    end
  endtask

  task automatic test_basic();
    int cyc;
    start_op(16'd100, 16'd7);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL basic_busy: busy=%b expected 1", busy);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc !== 18) begin
      n_fail++;
      $display("[TB] FAIL basic_latency: got %0d cycles expected 18", cyc);
    end
    n_checks++;
    if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_result: q=%0d r=%0d dbz=%b expected 14 2 0", quotient, remainder, div_by_zero);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 16'd14) begin
      n_fail++;
      $display("[TB] FAIL basic_after: done=%b busy=%b q=%0d expected 0 0 14", done, busy, quotient);
    end
  endtask

  task automatic test_boundaries();
    int cyc;
    start_op(16'hFFFF, 16'h0001);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 18 || quotient !== 16'hFFFF || remainder !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL max_by_one: cyc=%0d q=%h r=%h expected 18 ffff 0000", cyc, quotient, remainder);
    end
    tick();
    start_op(16'h0003, 16'h0010);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 18 || quotient !== 16'h0000 || remainder !== 16'h0003) begin
      n_fail++;
      $display("[TB] FAIL small_by_large: cyc=%0d q=%h r=%h expected 18 0000 0003", cyc, quotient, remainder);
    end
    tick();
  endtask

  task automatic test_div_zero();
    int cyc;
    start_op(16'd5, 16'd0);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 2) begin
      n_fail++;
      $display("[TB] FAIL zero_latency: got %0d cycles expected 2", cyc);
    end
    n_checks++;
    if (div_by_zero !== 1'b1 || quotient !== 16'hFFFF || remainder !== 16'd5) begin
      n_fail++;
      $display("[TB] FAIL zero_result: dbz=%b q=%h r=%h expected 1 ffff 0005", div_by_zero, quotient, remainder);
    end
    tick();
    n_checks++;
    if (div_by_zero !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL zero_hold: dbz=%b done=%b expected 1 0", div_by_zero, done);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    start_op(16'd100, 16'd7);
    repeat (5) tick();
    dividend = 16'd200;
    divisor  = 16'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ignore_busy: busy=%b done=%b expected 1 0", busy, done);
    end
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    // Cycle 7 when the stray start ended, so done should arrive 11 cycles later.
    n_checks++;
    if (cyc !== 11 || quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ignore_result: extra=%0d q=%0d r=%0d dbz=%b expected 11 14 2 0", cyc, quotient, remainder, div_by_zero);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_op(16'd1000, 16'd10);
    wait_done(cyc);
    n_checks++;
    if (quotient !== 16'd100 || remainder !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL b2b_first: q=%0d r=%0d expected 100 0", quotient, remainder);
    end
    start_op(16'd100, 16'd7);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_accept: busy=%b done=%b expected 1 0", busy, done);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc !== 18 || quotient !== 16'd14 || remainder !== 16'd2) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: cyc=%0d q=%0d r=%0d expected 18 14 2", cyc, quotient, remainder);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit saw_done;
    start_op(16'd1000, 16'd3);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 16'd0 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_clear: busy=%b done=%b q=%h r=%h dbz=%b expected all 0", busy, done, quotient, remainder, div_by_zero);
    end
    saw_done = 1'b0;
    repeat (20) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_done: saw_done=%b expected 0", saw_done);
    end
    start_op(16'd100, 16'd7);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 18 || quotient !== 16'd14 || remainder !== 16'd2) begin
      n_fail++;
      $display("[TB] FAIL abort_recover: cyc=%0d q=%0d r=%0d expected 18 14 2", cyc, quotient, remainder);
    end
    tick();
  endtask

  task automatic test_sign_mode();
    int cyc;
    logic [W-1:0] exp_q1, exp_r1, exp_q2, exp_r2;
`ifdef SEQ_DIVIDER_SIGNED_EN
    exp_q1 = 16'hFFFD; exp_r1 = 16'hFFFF;
    exp_q2 = 16'h8000; exp_r2 = 16'h0000;
`else
    exp_q1 = 16'h7FFC; exp_r1 = 16'h0001;
    exp_q2 = 16'h0000; exp_r2 = 16'h8000;
`endif
    start_op(16'hFFF9, 16'h0002);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 18 || quotient !== exp_q1 || remainder !== exp_r1) begin
      n_fail++;
      $display("[TB] FAIL mode_fff9_by_2: cyc=%0d q=%h r=%h expected 18 %h %h", cyc, quotient, remainder, exp_q1, exp_r1);
    end
    tick();
    start_op(16'h8000, 16'hFFFF);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 18 || quotient !== exp_q2 || remainder !== exp_r2) begin
      n_fail++;
      $display("[TB] FAIL mode_8000_by_ffff: cyc=%0d q=%h r=%h expected 18 %h %h", cyc, quotient, remainder, exp_q2, exp_r2);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_sign_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand, quotient and remainder width (WIDTH >= 2).
REQ-002 SHALL have parameter WIDTH_C, default $clog2(WIDTH+1), the iteration counter width.
REQ-003 SHALL use one clock and a synchronous, active-high reset; the ports are named clk and reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request a division; sampled only in IDLE or DONE.
REQ-007 SHALL have port dividend  input  WIDTH  numerator, captured in the cycle start is accepted.
REQ-008 SHALL have port divisor  input  WIDTH  denominator, captured in the cycle start is accepted.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress (LOAD or CALC).
REQ-010 SHALL have port done  output  1  single-cycle pulse; results valid in that cycle.
REQ-011 SHALL have port quotient  output  WIDTH  result quotient, held until the next accepted start.
REQ-012 SHALL have port remainder  output  WIDTH  result remainder, held until the next accepted start.
REQ-013 SHALL have port div_by_zero  output  1  divisor was zero, held alongside quotient and remainder.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, CALC and DONE.
REQ-015 SHALL accept start in IDLE or DONE: capture operands, clear the counter, go to LOAD.
REQ-016 SHALL ignore start while busy=1; the operation in progress is not disturbed.
REQ-017 SHALL go LOAD->DONE when the captured divisor is 0; otherwise LOAD->CALC.
REQ-018 SHALL perform one restoring step per CALC cycle, in this order:
- shift {rem,quo} left by 1;
- trial rem-divisor with WIDTH+1 bits;
- if the result is non-negative, keep the difference and set quo[0]=1;
- increment the counter.
REQ-019 SHALL leave CALC for DONE after exactly WIDTH steps (counter==WIDTH).
REQ-020 SHALL assert done exactly WIDTH+2 cycles after the accept edge, or 2 cycles for a zero divisor.
REQ-021 SHALL, for divisor 0, produce quotient all-ones, remainder=dividend and div_by_zero=1.
REQ-022 SHALL go DONE->IDLE after one cycle unless start is high in that cycle (back-to-back: DONE->LOAD).
REQ-023 SHALL update quotient, remainder and div_by_zero only on entry to DONE.

Reset
REQ-024 SHALL, while reset is high at a clk edge, force:
- state to IDLE;
- busy, done and div_by_zero to 0;
- quotient, remainder and the counter to 0.
REQ-025 SHALL abort any in-flight operation on reset with no done pulse, and reset SHALL take priority over start.

Configuration
REQ-026 SHALL support macro SEQ_DIVIDER_SIGNED_EN.
REQ-027 SHALL, when SEQ_DIVIDER_SIGNED_EN is defined, treat operands as two's complement:
- divide the magnitudes, then negate the quotient if the operand signs differ;
- give the remainder the dividend's sign;
- for most-negative/-1, return quotient=most-negative and remainder=0;
- for divide-by-zero, return quotient=-1 and remainder=dividend.
REQ-028 SHALL, when SEQ_DIVIDER_SIGNED_EN is undefined, treat operands as unsigned, with no sign logic synthesized.
REQ-029 SHALL keep latency identical in both modes.

Structure
REQ-030 SHALL place the following in package seq_div_pkg:
- state enum type div_state_t;
- default WIDTH constant;
- state encoding localparams.
REQ-031 SHALL put the combinational one-bit restoring step (shift, trial subtract, select) in sub-module div_step, instantiated once.

Verification (WIDTH=16)
REQ-032 Bench SHALL cover: 100/7 unsigned -> quotient 14, remainder 2, done 18 cycles after the accept edge.
REQ-033 Bench SHALL cover: 0xFFFF/0x0001 -> quotient 0xFFFF, remainder 0; 0x0003/0x0010 -> quotient 0, remainder 3.
REQ-034 Bench SHALL cover: 5/0 -> div_by_zero=1, quotient 0xFFFF, remainder 5, done 2 cycles after accept.
REQ-035 Bench SHALL cover: start pulsed mid-CALC with new operands -> ignored, original result unchanged; start high in DONE -> new op accepted, busy next cycle.
REQ-036 Bench SHALL cover: reset raised at CALC step 8 -> next cycle IDLE, all outputs 0, no done; a subsequent 100/7 is still correct.
REQ-037 Bench SHALL cover, with SEQ_DIVIDER_SIGNED_EN:
- -7/2 -> quotient 0xFFFD, remainder 0xFFFF;
- 0x8000/0xFFFF -> quotient 0x8000, remainder 0.
